// File: rtl/frame_sequencer.sv
// Frame-level scheduler for the pitch-shift datapath: counts input samples and
// walks each frame through overlap copy, FIR run and output-buffer write.
module frame_sequencer #(
    parameter int FRAME_LEN  = 1024,
    parameter int OUT_LEN_DN = 1024,
    parameter int OUT_LEN_UP = 576,
    parameter int COPY_LEN   = 64,
    parameter int FIR_CYC    = 32,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic          rising_tone,
    output logic [CW-1:0] sample_count,
    output logic          in_copy,
    output logic [CW-1:0] copy_addr,
    output logic          fir_start,
    output logic          fir_oe,
    output logic          out_buf_wea,
    output logic [CW-1:0] out_addr,
    output logic          mode,
    output logic          process_start,
    output logic          process_end,
    output logic          busy,
    output logic          overrun
);

    localparam int TW = (FIR_CYC > 1) ? $clog2(FIR_CYC) : 1;

    localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] COPY_LAST   = CW'(COPY_LEN - 1);
    localparam logic [CW-1:0] OUT_LAST_DN = CW'(OUT_LEN_DN - 1);
    localparam logic [CW-1:0] OUT_LAST_UP = CW'(OUT_LEN_UP - 1);
    localparam logic [TW-1:0] TAP_LAST    = TW'(FIR_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        FSTART,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          pending;
    logic [TW-1:0] tap;
    logic          frame_rdy;
    logic [CW-1:0] out_last;

    assign frame_rdy = ready && (sample_count == FRAME_LAST);
    assign out_last  = mode ? OUT_LAST_UP : OUT_LAST_DN;
    assign busy      = (state != IDLE);

    // Live samples always win the shared write port, so the copy grant has to
    // look at this cycle's ready rather than a registered copy of it.
    assign in_copy   = (state == COPY) && !ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_count <= '0;
        end else if (ready) begin
            sample_count <= (sample_count == FRAME_LAST) ? '0 : sample_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            mode          <= 1'b0;
            copy_addr     <= '0;
            out_addr      <= '0;
            tap           <= '0;
            fir_start     <= 1'b0;
            fir_oe        <= 1'b0;
            out_buf_wea   <= 1'b0;
            process_start <= 1'b0;
            process_end   <= 1'b0;
        end else begin
            process_start <= 1'b0;
            process_end   <= 1'b0;
            fir_start     <= 1'b0;
            out_buf_wea   <= 1'b0;

            // Only one frame can wait behind the one in flight; a second is dropped.
            if (frame_rdy && state != IDLE) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (frame_rdy || pending) begin
                        state         <= COPY;
                        process_start <= 1'b1;
                        mode          <= rising_tone;
                        pending       <= pending && frame_rdy;
                        copy_addr     <= '0;
                    end
                end
                COPY: begin
                    if (!ready) begin
                        if (copy_addr == COPY_LAST) begin
                            copy_addr <= '0;
                            fir_start <= 1'b1;
                            state     <= FSTART;
                        end else begin
                            copy_addr <= copy_addr + CW'(1);
                        end
                    end
                end
                FSTART: begin
                    tap    <= '0;
                    fir_oe <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    // The write strobe shows the address being written; advance afterwards.
                    if (out_buf_wea) begin
                        out_addr <= out_addr + CW'(1);
                    end
                    if (tap == TAP_LAST) begin
                        tap         <= '0;
                        out_buf_wea <= 1'b1;
                        if (out_addr == out_last) begin
                            fir_oe <= 1'b0;
                            state  <= DONE;
                        end
                    end else begin
                        tap <= tap + TW'(1);
                    end
                end
                DONE: begin
                    process_end <= 1'b1;
                    out_addr    <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
